step_sequencer: RTL
===================

Name: step_sequencer

Overview:
Downstream consumer of the trigger edge-detector's one-cycle `advance` pulse. Walks a programmable table of motor coil-phase patterns one entry per `advance` pulse, forward or reverse with wrap-around, for a programmed number of steps. Drives the registered phase pattern to the motor driver pins and reports progress and completion to the control block.

Parameters:
PHASE_WIDTH, 4, width of one coil-phase pattern (table entry and `phase_out`)
ADDR_WIDTH, 3, table index width; table depth is 2**ADDR_WIDTH entries
COUNT_WIDTH, 16, width of the step target and the step counter

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
advance  input  1  one-cycle step pulse from the edge-detector stage
start  input  1  one-cycle pulse; begins a run from IDLE
stop  input  1  level/pulse; aborts a run
direction  input  1  0 = forward (index increments), 1 = reverse; sampled on each step
seq_last  input  ADDR_WIDTH  index of the last valid table entry (sequence length - 1)
step_target  input  COUNT_WIDTH  steps to execute; sampled on `start`
wr_en  input  1  table write strobe
wr_addr  input  ADDR_WIDTH  table write address
wr_data  input  PHASE_WIDTH  table write data
phase_out  output  PHASE_WIDTH  registered coil-phase pattern
step_index  output  ADDR_WIDTH  current table index
steps_done  output  COUNT_WIDTH  steps taken in the current or last run
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run ends by reaching `step_target`

Behaviour:
- Reset (async, any time, including mid-run):
  - all table entries = 0; `phase_out` = 0; `step_index` = 0; `steps_done` = 0; `busy` = 0; `done` = 0; state = IDLE.
- Table write:
  - synchronous; on `wr_en`, table[`wr_addr`] <= `wr_data`. Allowed in any state.
  - A write never updates `phase_out` directly. The new value is picked up on the next load/step that reads that entry.
  - If a write and a read of the same entry occur in the same cycle, the read returns the old value.
- States: IDLE, RUN, DONE.
- IDLE:
  - `busy` = 0; `phase_out` holds its last value (holding torque); `advance` ignored.
  - On `start`: latch `step_target`, clear `steps_done`, load `phase_out` <= table[`step_index`] (index unchanged).
  - If the latched target is 0, go to DONE; otherwise go to RUN.
  - `start` and `advance` in the same cycle: only `start` acts.
- RUN:
  - `busy` = 1. `start` is ignored.
  - On `stop`: go to IDLE without stepping. `stop` wins over a simultaneous `advance`. `done` does not pulse; `steps_done` holds its value.
  - On `advance` (no `stop`), compute the next index:
    - Forward: `step_index` == `seq_last` or `step_index` > `seq_last` gives 0; otherwise `step_index` + 1.
    - Reverse: `step_index` == 0 or `step_index` > `seq_last` gives `seq_last`; otherwise `step_index` - 1.
  - On the same edge: `step_index` <= next index, `phase_out` <= table[next index], `steps_done` <= `steps_done` + 1.
  - If `steps_done` + 1 == latched target, go to DONE.
  - Latency: `phase_out` and `step_index` change on the clock edge that samples `advance`, i.e. they are visible 1 cycle after the pulse.
  - `direction` and `seq_last` may change between steps and take effect on the next step.
- DONE:
  - Lasts exactly one cycle: `done` = 1, `busy` = 0, then go to IDLE unconditionally.
  - `advance`, `start` and `stop` are ignored in this cycle.
- `steps_done` never wraps: the terminal compare ends the run first. Arithmetic is unsigned at COUNT_WIDTH.
- `start` while in RUN or DONE is dropped, not queued.

Test Plan:
- Reset → all outputs are 0.
- Load table 0..3 = 4'b0001, 4'b0010, 4'b0100, 4'b1000; set `seq_last` = 3, `direction` = 0, `step_target` = 6; pulse `start`, then 6 `advance` pulses spaced 10 cycles apart.
  - Required: `phase_out` sequence 0001 (on start), then 0010, 0100, 1000, 0001, 0010, 0100.
  - Required: `step_index` ends at 2; one `done` pulse the cycle after the 6th step edge; `busy` 0 afterwards.
- Same table, `step_index` = 0, `direction` = 1, `step_target` = 3 → `phase_out` sequence 1000, 0100, 0010; `step_index` ends at 1.
- RUN with `step_target` = 10; after 4 steps assert `stop` in the same cycle as `advance`.
  - Required: no 5th step; state IDLE; `steps_done` = 4; no `done` pulse; `phase_out` held.
- `step_target` = 0, then `start` → `done` pulses on the 2nd cycle; `busy` never goes high; `steps_done` = 0; `phase_out` = table[`step_index`].
- Mid-run async `reset` between clock edges → outputs clear immediately without a clock edge; subsequent `advance` pulses are ignored until the next `start`.
- `step_index` = 5 with `seq_last` lowered to 3, then one forward step → `step_index` = 0. Same setup with a reverse step → `step_index` = 3.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the motor control block and the step sequencer.
// Latency: none (wires only).
// Backpressure: none; advance/start are single-cycle pulses, consumer never stalls.
interface step_sequencer_if #(
    parameter int PHASE_WIDTH = 4,
    parameter int ADDR_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16
);
    logic                   advance;
    logic                   start;
    logic                   stop;
    logic                   direction;
    logic [ADDR_WIDTH-1:0]  seq_last;
    logic [COUNT_WIDTH-1:0] step_target;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [PHASE_WIDTH-1:0] wr_data;
    logic [PHASE_WIDTH-1:0] phase_out;
    logic [ADDR_WIDTH-1:0]  step_index;
    logic [COUNT_WIDTH-1:0] steps_done;
    logic                   busy;
    logic                   done;

    // Control side: issues commands and table writes, observes progress.
    modport master (
        output advance, start, stop, direction, seq_last, step_target,
        output wr_en, wr_addr, wr_data,
        input  phase_out, step_index, steps_done, busy, done
    );

    // Sequencer side.
    modport slave (
        input  advance, start, stop, direction, seq_last, step_target,
        input  wr_en, wr_addr, wr_data,
        output phase_out, step_index, steps_done, busy, done
    );
endinterface

// File: rtl/step_sequencer.sv
// Walks a coil-phase table one entry per advance pulse, fwd/rev with wrap, for a set step count.
// Latency: phase_out/step_index update on the edge that samples advance (visible 1 cycle later).
// Backpressure: none; advance outside RUN and start outside IDLE are dropped, not queued.
module step_sequencer #(
    parameter int PHASE_WIDTH = 4,
    parameter int ADDR_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    step_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PHASE_WIDTH-1:0] phase_tab [DEPTH];
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [ADDR_WIDTH-1:0]  index_q;
    logic [ADDR_WIDTH-1:0]  index_nxt;
    logic [COUNT_WIDTH-1:0] steps_q;
    logic [COUNT_WIDTH-1:0] steps_inc;
    logic [COUNT_WIDTH-1:0] target_q;
    logic                   load_en;
    logic                   step_en;

    assign steps_inc = steps_q + COUNT_WIDTH'(1);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus load/step strobes; stop outranks advance, DONE is a single cycle.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        step_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load_en   = 1'b1;
                    state_nxt = (bus.step_target == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.advance) begin
                    step_en = 1'b1;
                    if (steps_inc == target_q) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next table index; an index stranded above seq_last re-enters at the wrap point.
    always_comb begin
        index_nxt = index_q + ADDR_WIDTH'(1);
        if (bus.direction) begin
            if ((index_q == '0) || (index_q > bus.seq_last)) begin
                index_nxt = bus.seq_last;
            end else begin
                index_nxt = index_q - ADDR_WIDTH'(1);
            end
        end else if (index_q >= bus.seq_last) begin
            index_nxt = '0;
        end
    end

    // Pattern table; reads in the same cycle see the pre-write contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                phase_tab[i] <= '0;
            end
        end else if (bus.wr_en) begin
            phase_tab[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Run datapath: load on start, advance index/pattern/count on each accepted step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= '0;
            index_q  <= '0;
            steps_q  <= '0;
            target_q <= '0;
        end else if (load_en) begin
            target_q <= bus.step_target;
            steps_q  <= '0;
            phase_q  <= phase_tab[index_q];
        end else if (step_en) begin
            index_q  <= index_nxt;
            phase_q  <= phase_tab[index_nxt];
            steps_q  <= steps_inc;
        end
    end

    assign bus.phase_out  = phase_q;
    assign bus.step_index = index_q;
    assign bus.steps_done = steps_q;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);
endmodule
